wbu_pipe: RTL and testbench

Pipelined writeback stage for the rv32 NPC core.
- Accepts one retiring instruction per handshake from the LSU side.
- Selects the writeback source from ALU, load, static next-PC (snpc) or CSR.
- For loads, waits for the memory response, then extracts and sign- or zero-extends the correct byte lane.
- Drives the register-file write port and a one-cycle commit pulse consumed by difftest.

---
 rtl/rv32_pkg.sv | 37 +++
 rtl/load_extend.sv | 40 ++++
 rtl/wbu_pipe.sv | 186 ++++++++++++++++++
 tb/tb_wbu_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared encodings for the rv32 NPC core: writeback-source selector,
// load-size codes and the writeback-stage FSM state encoding.
package rv32_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_SNPC = 2'd2,
        WB_SEL_CSR  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_SIZE_B   = 2'd0,
        LD_SIZE_H   = 2'd1,
        LD_SIZE_W   = 2'd2,
        LD_SIZE_RSV = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } wbu_state_e;

    // A byte can never be misaligned; halves need bit 0 clear; words (and the
    // reserved size, which behaves as a word) need both low bits clear.
    function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LD_SIZE_B: mis = 1'b0;
            LD_SIZE_H: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-lane extraction with sign/zero extension and a
// misalignment flag. Misaligned accesses still return the lane selected by
// the address bits so the caller can decide what to do with the flag.
module load_extend
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;
    logic        byte_sign_s;
    logic        half_sign_s;

    // Pick the addressed byte / half lane; halves only use addr_lo[1].
    always_comb begin
        byte_lane_s = rdata[{addr_lo, 3'b000} +: 8];
        half_lane_s = rdata[{addr_lo[1], 4'b0000} +: 16];
        byte_sign_s = byte_lane_s[7] & ~ld_unsigned;
        half_sign_s = half_lane_s[15] & ~ld_unsigned;
    end

    // Extend the selected lane according to the access size.
    always_comb begin
        case (size)
            LD_SIZE_B: data = {{(XLEN-8){byte_sign_s}}, byte_lane_s};
            LD_SIZE_H: data = {{(XLEN-16){half_sign_s}}, half_lane_s};
            default:   data = rdata;
        endcase
        misalign = ld_misaligned(size, addr_lo);
    end

endmodule

// File: rtl/wbu_pipe.sv
// Writeback stage of the rv32 NPC core. Accepts one retiring instruction,
// waits for the memory response on loads, then drives a one-cycle
// register-file write and commit pulse from registered outputs.
module wbu_pipe
    import rv32_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5,
    parameter int SEL_W     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_wb_sel,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_snpc,
    input  logic [XLEN-1:0]      in_csr_rdata,
    input  logic [RF_ADDR_W-1:0] in_rd,
    input  logic                 in_rf_wen,
    input  logic [1:0]           in_ld_size,
    input  logic                 in_ld_unsigned,
    input  logic [1:0]           in_addr_lo,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rf_wen,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 commit_valid,
    output logic                 commit_misalign
);

    wbu_state_e           state_q, state_d;

    // Fields of the accepted instruction needed while a load is outstanding
    logic [RF_ADDR_W-1:0] rd_q, rd_d;
    logic                 wen_cap_q, wen_cap_d;
    logic [1:0]           ld_size_q, ld_size_d;
    logic                 ld_uns_q, ld_uns_d;
    logic [1:0]           addr_lo_q, addr_lo_d;

    // Registered outputs
    logic                 rf_wen_q, rf_wen_d;
    logic [RF_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 commit_valid_q, commit_valid_d;
    logic                 commit_misalign_q, commit_misalign_d;

    logic                 accept_s;
    logic                 is_load_s;
    logic [XLEN-1:0]      direct_wdata_s;
    logic [XLEN-1:0]      ld_data_s;
    logic                 ld_misalign_s;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata       (mem_rdata),
        .size        (ld_size_q),
        .ld_unsigned (ld_uns_q),
        .addr_lo     (addr_lo_q),
        .data        (ld_data_s),
        .misalign    (ld_misalign_s)
    );

    // Handshake decode and non-load writeback source selection.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        accept_s  = in_valid && (state_q == ST_IDLE);
        is_load_s = (in_wb_sel == SEL_W'(WB_SEL_LOAD));
        case (in_wb_sel)
            SEL_W'(WB_SEL_SNPC): direct_wdata_s = in_snpc;
            SEL_W'(WB_SEL_CSR):  direct_wdata_s = in_csr_rdata;
            default:             direct_wdata_s = in_alu_result;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = is_load_s ? ST_WAIT_MEM : ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Capture instruction fields on acceptance.
    always_comb begin
        rd_d      = rd_q;
        wen_cap_d = wen_cap_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        addr_lo_d = addr_lo_q;
        if (accept_s) begin
            rd_d      = in_rd;
            wen_cap_d = in_rf_wen;
            ld_size_d = in_ld_size;
            ld_uns_d  = in_ld_unsigned;
            addr_lo_d = in_addr_lo;
        end else begin
            rd_d = rd_q;
        end
    end

    // Output logic: load the output registers on the edge that enters COMMIT
    // so they are visible for exactly the COMMIT cycle.
    always_comb begin
        rf_wen_d          = 1'b0;
        commit_valid_d    = 1'b0;
        commit_misalign_d = 1'b0;
        rf_waddr_d        = rf_waddr_q;
        rf_wdata_d        = rf_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !is_load_s) begin
                    commit_valid_d = 1'b1;
                    rf_wen_d       = in_rf_wen && (in_rd != '0);
                    rf_waddr_d     = in_rd;
                    rf_wdata_d     = direct_wdata_s;
                end else begin
                    commit_valid_d = 1'b0;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    commit_valid_d    = 1'b1;
                    rf_wen_d          = wen_cap_q && (rd_q != '0);
                    rf_waddr_d        = rd_q;
                    rf_wdata_d        = ld_data_s;
                    commit_misalign_d = ld_misalign_s;
                end else begin
                    commit_valid_d = 1'b0;
                end
            end
            default: commit_valid_d = 1'b0;
        endcase
    end

    // State, captured fields and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            rd_q              <= '0;
            wen_cap_q         <= 1'b0;
            ld_size_q         <= 2'b00;
            ld_uns_q          <= 1'b0;
            addr_lo_q         <= 2'b00;
            rf_wen_q          <= 1'b0;
            rf_waddr_q        <= '0;
            rf_wdata_q        <= '0;
            commit_valid_q    <= 1'b0;
            commit_misalign_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            rd_q              <= rd_d;
            wen_cap_q         <= wen_cap_d;
            ld_size_q         <= ld_size_d;
            ld_uns_q          <= ld_uns_d;
            addr_lo_q         <= addr_lo_d;
            rf_wen_q          <= rf_wen_d;
            rf_waddr_q        <= rf_waddr_d;
            rf_wdata_q        <= rf_wdata_d;
            commit_valid_q    <= commit_valid_d;
            commit_misalign_q <= commit_misalign_d;
        end
    end

    assign rf_wen          = rf_wen_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;
    assign commit_valid    = commit_valid_q;
    assign commit_misalign = commit_misalign_q;

endmodule

// File: tb/tb_wbu_pipe.sv
// Directed scoreboard bench for wbu_pipe.
module tb_wbu_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_snpc;
    logic [31:0] in_csr_rdata;
    logic [4:0]  in_rd;
    logic        in_rf_wen;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic        commit_misalign;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    wbu_pipe dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_wb_sel       (in_wb_sel),
        .in_alu_result   (in_alu_result),
        .in_snpc         (in_snpc),
        .in_csr_rdata    (in_csr_rdata),
        .in_rd           (in_rd),
        .in_rf_wen       (in_rf_wen),
        .in_ld_size      (in_ld_size),
        .in_ld_unsigned  (in_ld_unsigned),
        .in_addr_lo      (in_addr_lo),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .rf_wen          (rf_wen),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .commit_valid    (commit_valid),
        .commit_misalign (commit_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata, input logic mis);
        exp_t e;
        e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.mis = mis;
        sb.push_back(e);
    endtask

    // Called at a negedge inside the commit cycle.
    task automatic expect_commit(input string tag);
        exp_t e;
        chk({tag, ".commit_valid"}, 32'(commit_valid), 32'd1);
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".rf_wen"},   32'(rf_wen),          32'(e.wen));
            chk({tag, ".rf_waddr"}, 32'(rf_waddr),        32'(e.waddr));
            chk({tag, ".rf_wdata"}, rf_wdata,             e.wdata);
            chk({tag, ".misalign"}, 32'(commit_misalign), 32'(e.mis));
        end
    endtask

    // Called at a negedge while IDLE; returns just after the accepting edge.
    task automatic issue(input string tag, input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                         input logic [31:0] alu, input logic [31:0] snpc, input logic [31:0] csr,
                         input logic [1:0] size, input logic uns, input logic [1:0] addr);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_wb_sel = sel; in_rd = rd; in_rf_wen = wen;
        in_alu_result = alu; in_snpc = snpc; in_csr_rdata = csr;
        in_ld_size = size; in_ld_unsigned = uns; in_addr_lo = addr;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    // Drive a one-cycle memory response, end at the following negedge.
    task automatic mem_resp(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(posedge clock);
        #1 mem_rvalid = 1'b0;
        @(negedge clock);
    endtask

    // Complete load: issue, respond in the next cycle, check the commit.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [1:0] size, input logic uns,
                           input logic [1:0] addr, input logic [31:0] rdata, input logic [31:0] exp_data,
                           input logic exp_mis);
        issue(tag, 2'd1, rd, 1'b1, 32'h0BAD_0BAD, 32'h0BAD_0BAD, 32'h0BAD_0BAD, size, uns, addr);
        push(1'b1, rd, exp_data, exp_mis);
        @(negedge clock);
        chk({tag, ".wait_ready"}, 32'(in_ready), 32'd0);
        mem_resp(rdata);
        expect_commit(tag);
        @(negedge clock);
        chk({tag, ".after_cv"}, 32'(commit_valid), 32'd0);
        chk({tag, ".after_mis"}, 32'(commit_misalign), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_wb_sel = 2'd0; in_alu_result = 32'd0;
        in_snpc = 32'd0; in_csr_rdata = 32'd0; in_rd = 5'd0; in_rf_wen = 1'b0;
        in_ld_size = 2'd0; in_ld_unsigned = 1'b0; in_addr_lo = 2'd0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset values
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.rf_wen", 32'(rf_wen), 32'd0);
        chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst.rf_wdata", rf_wdata, 32'd0);
        chk("rst.commit_valid", 32'(commit_valid), 32'd0);
        chk("rst.misalign", 32'(commit_misalign), 32'd0);

        // 1. ALU op, one-cycle latency, outputs hold after commit
        @(negedge clock);
        issue("alu", 2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h1111_1111, 32'h2222_2222, 2'd2, 1'b0, 2'd0);
        push(1'b1, 5'd5, 32'h0000_1234, 1'b0);
        @(negedge clock);
        expect_commit("alu");
        chk("alu.busy", 32'(in_ready), 32'd0);
        @(negedge clock);
        chk("alu.ready_again", 32'(in_ready), 32'd1);
        chk("alu.cv_low", 32'(commit_valid), 32'd0);
        chk("alu.wen_low", 32'(rf_wen), 32'd0);
        chk("alu.waddr_hold", 32'(rf_waddr), 32'd5);
        chk("alu.wdata_hold", rf_wdata, 32'h0000_1234);

        // 2. LB signed, three wait cycles before the response
        issue("lb", 2'd1, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd3);
        push(1'b1, 5'd6, 32'hFFFF_FF80, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("lb.wait_ready", 32'(in_ready), 32'd0);
            chk("lb.wait_cv", 32'(commit_valid), 32'd0);
        end
        mem_resp(32'h80FF_FFFF);
        expect_commit("lb");
        @(negedge clock);

        // 3. Load lane / extension / misalign variety
        do_load("lhu", 5'd7, 2'd1, 1'b1, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF, 1'b0);
        do_load("lw_mis", 5'd8, 2'd2, 1'b0, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
        do_load("lh", 5'd9, 2'd1, 1'b0, 2'd0, 32'h1234_8001, 32'hFFFF_8001, 1'b0);
        do_load("lbu", 5'd10, 2'd0, 1'b1, 2'd1, 32'h1234_AB00, 32'h0000_00AB, 1'b0);
        do_load("lh_mis", 5'd11, 2'd1, 1'b0, 2'd3, 32'h7FFF_0000, 32'h0000_7FFF, 1'b1);
        do_load("lrsv", 5'd12, 2'd3, 1'b0, 2'd0, 32'h8765_4321, 32'h8765_4321, 1'b0);

        // 4. JAL link, rd=0, and a non-writing commit
        issue("jal", 2'd2, 5'd1, 1'b1, 32'h0000_DEAD, 32'h8000_0004, 32'h0000_BEEF, 2'd0, 1'b0, 2'd0);
        push(1'b1, 5'd1, 32'h8000_0004, 1'b0);
        @(negedge clock); expect_commit("jal"); @(negedge clock);
        issue("jal_x0", 2'd2, 5'd0, 1'b1, 32'h0000_DEAD, 32'h8000_0008, 32'h0000_BEEF, 2'd0, 1'b0, 2'd0);
        push(1'b0, 5'd0, 32'h8000_0008, 1'b0);
        @(negedge clock); expect_commit("jal_x0"); @(negedge clock);
        issue("store", 2'd0, 5'd7, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
        push(1'b0, 5'd7, 32'h0000_0055, 1'b0);
        @(negedge clock); expect_commit("store"); @(negedge clock);

        // 5. Reset while a load is pending
        issue("rstld", 2'd1, 5'd13, 1'b1, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 2'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstld.in_ready", 32'(in_ready), 32'd1);
        chk("rstld.cv", 32'(commit_valid), 32'd0);
        chk("rstld.waddr", 32'(rf_waddr), 32'd0);
        chk("rstld.wdata", rf_wdata, 32'd0);
        mem_resp(32'h1111_1111);
        chk("rstld.late_cv", 32'(commit_valid), 32'd0);
        chk("rstld.late_wen", 32'(rf_wen), 32'd0);
        @(negedge clock);
        chk("rstld.late_cv2", 32'(commit_valid), 32'd0);
        chk("rstld.late_wdata", rf_wdata, 32'd0);
        chk("rstld.ready2", 32'(in_ready), 32'd1);

        // 6. Back-to-back CSR ops with in_valid held, stray mem_rvalid in IDLE
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                chk("b2b.ready_hi", 32'(in_ready), 32'd1);
                chk("b2b.cv_lo", 32'(commit_valid), 32'd0);
                in_wb_sel = 2'd3;
                in_rd = 5'(14 + k / 2);
                in_rf_wen = 1'b1;
                in_csr_rdata = 32'hC500_0000 + 32'(k);
                in_alu_result = 32'hA100_0000;
                in_valid = 1'b1;
                push(1'b1, 5'(14 + k / 2), 32'hC500_0000 + 32'(k), 1'b0);
                if (k == 4) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = 32'hFFFF_FFFF;
                end else begin
                    mem_rvalid = 1'b0;
                end
            end else begin
                mem_rvalid = 1'b0;
                chk("b2b.ready_lo", 32'(in_ready), 32'd0);
                expect_commit("b2b");
                if (k == 7) in_valid = 1'b0;
            end
            @(negedge clock);
        end
        chk("b2b.final_cv", 32'(commit_valid), 32'd0);
        chk("b2b.final_ready", 32'(in_ready), 32'd1);
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
